// File: rtl/byte_serializer_pkg.sv
// Shared state encoding and size limits for byte_serializer and its shifter.
package byte_serializer_pkg;

  localparam int unsigned WIDTH_MAX    = 16;
  localparam int unsigned IDLE_GAP_MAX = 15;
  localparam int unsigned CNT_W        = $clog2(WIDTH_MAX);
  localparam int unsigned GAP_W        = $clog2(IDLE_GAP_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } ser_state_e;

endpackage

// File: rtl/serializer_shift_reg.sv
// Loadable MSB-first shift register with frame bit counter and last-bit flag.
module serializer_shift_reg
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-2:0] data_i,
  output logic             next_bit_o,
  output logic             last_o
);

  // Only the bits after the MSB are held here; the MSB goes straight to the
  // output register on the load edge, so next_bit_o is always the bit to emit next.
  logic [WIDTH-2:0] sh_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign next_bit_o = sh_q[WIDTH-2];
  assign last_o     = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial framer with one-entry holding register, MSB first.
// Optional even-parity bit per frame when SERIALIZER_PARITY_EN is defined.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dataout,
  output logic             dataout_valid,
  output logic             busy
);

  localparam logic [GAP_W-1:0] GAP_LAST = (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dout_q, dout_d;
  logic             doutv_q, doutv_d;
  logic             load, shift, accept;
  logic             next_bit, last_bit;
  logic             frame_done, gap_done;

  assign din_ready = ~hold_full_q;
  assign accept    = din_valid & din_ready;
  assign busy      = (state_q != ST_IDLE) | hold_full_q;

  serializer_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (hold_q[WIDTH-2:0]),
    .next_bit_o(next_bit),
    .last_o    (last_bit)
  );

`ifdef SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^hold_q;
    end
  end

  assign frame_done = (state_q == ST_PARITY);
`else
  assign frame_done = (state_q == ST_SHIFT) && last_bit;
`endif

  assign gap_done = (state_q == ST_GAP) && (gap_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    dout_d  = 1'b0;
    doutv_d = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;

    unique case (state_q)
      ST_SHIFT: begin
        if (!last_bit) begin
          shift   = 1'b1;
          dout_d  = next_bit;
          doutv_d = 1'b1;
        end
`ifdef SERIALIZER_PARITY_EN
        else begin
          state_d = ST_PARITY;
          dout_d  = par_q;
          doutv_d = 1'b1;
        end
`endif
      end
      ST_GAP:  gap_d = gap_q + 1'b1;
      default: ;
    endcase

    // Idle, end of gap and end of a gapless frame all share the reload path,
    // so a held word starts on the very next edge without a bubble.
    if (frame_done && (IDLE_GAP != 0)) begin
      state_d = ST_GAP;
      gap_d   = '0;
    end else if ((state_q == ST_IDLE) || gap_done || frame_done) begin
      state_d = hold_full_q ? ST_SHIFT : ST_IDLE;
      load    = hold_full_q;
      dout_d  = hold_full_q & hold_q[WIDTH-1];
      doutv_d = hold_full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      gap_q       <= '0;
      dout_q      <= 1'b0;
      doutv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      doutv_q <= doutv_d;
      if (accept) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign dataout       = dout_q;
  assign dataout_valid = doutv_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: table of single words plus streaming,
// idle-gap and mid-frame reset sequences on two instances (IDLE_GAP 0 and 3).
module tb_byte_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, g_din;
  logic       din_valid, g_din_valid;
  logic       din_ready, dataout, dataout_valid, busy;
  logic       g_din_ready, g_dataout, g_dataout_valid, g_busy;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .IDLE_GAP(0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dataout(dataout), .dataout_valid(dataout_valid), .busy(busy)
  );

  byte_serializer #(.WIDTH(8), .IDLE_GAP(3)) u_gap (
    .clk(clk), .rst(rst), .din(g_din), .din_valid(g_din_valid), .din_ready(g_din_ready),
    .dataout(g_dataout), .dataout_valid(g_dataout_valid), .busy(g_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic rec_v [48];
  logic rec_d [48];

  typedef struct {
    logic [7:0] word;
    logic       par;   // hand-computed even parity of word
    int         n101;  // hand-counted 101 patterns in the zero-padded frame
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] w, input logic p, input int i);
    if (i >= 8) return p;
    return w[7-i];
  endfunction

  task automatic drive(input bit g, input logic [7:0] w, input logic v);
    if (g) begin g_din = w; g_din_valid = v; end
    else   begin din = w;   din_valid = v;   end
  endtask

  function automatic logic rdy(input bit g);
    return g ? g_din_ready : din_ready;
  endfunction

  task automatic send_single(input logic [7:0] w, input logic p, input int n101);
    logic [2:0] hist;
    int         pulses;
    hist   = '0;
    pulses = 0;
    @(negedge clk);
    check($sformatf("ready idle %02h", w), din_ready, 1);
    din = w; din_valid = 1'b1;
    @(negedge clk);
    din = ~w; din_valid = 1'b0;
    check($sformatf("pre-frame valid %02h", w), dataout_valid, 0);
    check($sformatf("ready while held %02h", w), din_ready, 0);
    check($sformatf("busy while held %02h", w), busy, 1);
    hist = {hist[1:0], dataout};
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      check($sformatf("bit%0d of %02h", i, w), {dataout_valid, dataout}, {1'b1, fbit(w, p, i)});
      hist = {hist[1:0], dataout};
      if (hist == 3'b101) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-frame%0d of %02h", i, w), {dataout_valid, dataout}, 2'b00);
      hist = {hist[1:0], dataout};
      if (hist == 3'b101) pulses++;
    end
    check($sformatf("idle busy %02h", w), busy, 0);
    check($sformatf("101 pulses %02h", w), pulses, n101);
  endtask

  task automatic run_stream(input bit g, input logic [7:0] w0, input logic p0,
                            input logic [7:0] w1, input logic p1, input int gap, input string tag);
    logic [7:0] words [2];
    int         idx, first, nvalid, len;
    bit         pend;
    logic [1:0] ev;
    words[0] = w0;
    words[1] = w1;
    idx = 0;
    @(negedge clk);
    drive(g, w0, 1'b1);
    pend = rdy(g);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (pend) begin
        idx++;
        if (idx < 2) drive(g, words[idx], 1'b1);
        else         drive(g, 8'h00, 1'b0);
      end
      rec_v[c] = g ? g_dataout_valid : dataout_valid;
      rec_d[c] = g ? g_dataout : dataout;
      pend = (g ? g_din_valid : din_valid) && rdy(g);
    end
    first  = -1;
    nvalid = 0;
    for (int c = 0; c < 48; c++) begin
      if (rec_v[c]) begin
        nvalid++;
        if (first < 0) first = c;
      end
    end
    len = 2 * FLEN + gap + 2;
    check({tag, " latency"}, first, 1);
    check({tag, " valid count"}, nvalid, 2 * FLEN);
    if (first < 0 || first > 48 - len) first = 0;
    for (int k = 0; k < len; k++) begin
      if (k < FLEN)                 ev = {1'b1, fbit(w0, p0, k)};
      else if (k < FLEN + gap)      ev = 2'b00;
      else if (k < 2 * FLEN + gap)  ev = {1'b1, fbit(w1, p1, k - FLEN - gap)};
      else                          ev = 2'b00;
      check($sformatf("%s pos%0d", tag, k), {rec_v[first+k], rec_d[first+k]}, ev);
    end
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{8'hA5, 1'b0, 2};
    vecs[1]  = '{8'h07, 1'b1, 0};
    vecs[2]  = '{8'h03, 1'b0, 0};
    vecs[3]  = '{8'hFF, 1'b0, 0};
    vecs[4]  = '{8'h00, 1'b0, 0};
    vecs[5]  = '{8'h81, 1'b0, 0};
    vecs[6]  = '{8'h3C, 1'b0, 0};
    vecs[7]  = '{8'h01, 1'b1, 0};
    vecs[8]  = '{8'h80, 1'b1, 0};
    vecs[9]  = '{8'h28, 1'b0, 1};
    vecs[10] = '{8'h6C, 1'b0, 1};

    // Reset with valid asserted: nothing may be accepted while rst is high.
    rst = 1'b1;
    din = 8'hFF; din_valid = 1'b1;
    g_din = 8'hFF; g_din_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst dataout_valid", dataout_valid, 0);
    check("rst dataout", dataout, 0);
    check("rst busy", busy, 0);
    check("rst din_ready", din_ready, 1);
    check("rst gap busy", g_busy, 0);
    check("rst gap dataout_valid", g_dataout_valid, 0);
    rst = 1'b0;
    din_valid = 1'b0;
    g_din_valid = 1'b0;

    foreach (vecs[i]) send_single(vecs[i].word, vecs[i].par, vecs[i].n101);

    run_stream(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 0, "b2b FF/00");
    run_stream(1'b1, 8'h81, 1'b0, 8'h81, 1'b0, 3, "gap3 81/81");
    run_stream(1'b0, 8'hA5, 1'b0, 8'h07, 1'b1, 0, "b2b A5/07");

    // Reset on the 4th bit of C3 while 55 sits in the holding register.
    @(negedge clk);
    check("mid ready", din_ready, 1);
    din = 8'hC3; din_valid = 1'b1;
    @(negedge clk);
    din = 8'h55; din_valid = 1'b1;
    @(negedge clk);
    check("mid bit0", {dataout_valid, dataout}, 2'b11);
    check("mid ready after load", din_ready, 1);
    @(negedge clk);
    din_valid = 1'b0;
    check("mid held", din_ready, 0);
    check("mid bit1", {dataout_valid, dataout}, 2'b11);
    @(negedge clk);
    check("mid bit2", {dataout_valid, dataout}, 2'b10);
    @(negedge clk);
    check("mid bit3", {dataout_valid, dataout}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst dataout_valid", dataout_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst din_ready", din_ready, 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dataout_valid) cnt++;
    end
    check("held word discarded", cnt, 0);

    send_single(8'h28, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
